mips_mem_arbiter: RTL and testbench

//  Shares one single-port unified memory between the core's instruction-fetch path (PC-indexed)
//  and its load/store data path. Arbitrates, issues one access at a time, waits a fixed latency,

---
 rtl/mips_mem_arbiter_pkg.sv | 14 +
 rtl/mips_mem_arbiter_if.sv | 44 ++++
 rtl/mem_lat_counter.sv | 27 ++
 rtl/mips_mem_arbiter.sv | 102 ++++++++++
 tb/tb_mips_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_arbiter_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
// Holds the FSM state encoding and default timing parameters.
package mips_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } arb_state_e;

  localparam int DEF_MEM_LAT       = 2;
  localparam int DEF_MAX_DM_STREAK = 4;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Fetch, data and memory-side bus of the memory arbiter.
// slave = arbiter view, master = core/memory view.
interface mips_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [ADDR_W-1:0] if_rdata;
  logic              if_valid;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_dm;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_rdata, if_valid,
    output dm_rdata, dm_valid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_dm
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_rdata, if_valid,
    input  dm_rdata, dm_valid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_dm
  );
endinterface

// File: rtl/mem_lat_counter.sv
// Memory latency down-counter: loads MEM_LAT-1 on issue,
// decrements to zero, flags zero on the completion cycle.
module mem_lat_counter #(
  parameter int MEM_LAT = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  output logic zero
);
  localparam int CW = $clog2(MEM_LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(MEM_LAT - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter between fetch and load/store paths.
// One access in flight; data wins ties unless fetch has starved.
module mips_mem_arbiter
  import mips_mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT       = DEF_MEM_LAT,
  parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK
) (
  input  logic              clock,
  input  logic              reset_n,
  mips_mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DM_STREAK);

  arb_state_e    st, st_nxt;
  logic [SW-1:0] streak;
  logic          op_we;
  logic          cnt_zero;
  logic          grant_if;
  logic          grant_dm;
  logic          grant;
  logic          done_if;
  logic          done_dm;
  logic          starved;

  assign grant   = grant_if | grant_dm;
  assign starved = bus.if_req && (streak == SMAX);
  assign done_if = (st == ST_BUSY_IF) && cnt_zero;
  assign done_dm = (st == ST_BUSY_DM) && cnt_zero;

  mem_lat_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (grant),
    .zero    (cnt_zero)
  );

  always_comb begin
    st_nxt   = st;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (bus.dm_req && !starved) begin
          grant_dm = 1'b1;
          st_nxt   = ST_BUSY_DM;
        end else if (bus.if_req) begin
          grant_if = 1'b1;
          st_nxt   = ST_BUSY_IF;
        end
      end
      ST_BUSY_IF,
      ST_BUSY_DM: begin
        if (cnt_zero) st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st            <= ST_IDLE;
      streak        <= '0;
      op_we         <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.if_valid  <= 1'b0;
      bus.dm_rdata  <= '0;
      bus.dm_valid  <= 1'b0;
    end else begin
      st           <= st_nxt;
      bus.mem_en   <= grant;
      bus.mem_we   <= grant_dm & bus.dm_we;
      bus.if_valid <= done_if;
      bus.dm_valid <= done_dm;
      if (grant) begin
        op_we         <= grant_dm & bus.dm_we;
        bus.mem_addr  <= grant_dm ? bus.dm_addr : bus.if_addr;
        bus.mem_wdata <= grant_dm ? bus.dm_wdata : '0;
      end
      if (done_if) bus.if_rdata <= bus.mem_rdata;
      if (done_dm && !op_we) bus.dm_rdata <= bus.mem_rdata;
      // streak only counts data grants that made fetch wait
      if (grant_if) begin
        streak <= '0;
      end else if (grant_dm) begin
        if (!bus.if_req)        streak <= '0;
        else if (streak != SMAX) streak <= streak + SW'(1);
      end
    end
  end

  assign bus.stall_if = bus.if_req & ~bus.if_valid;
  assign bus.stall_dm = bus.dm_req & ~bus.dm_valid;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed + randomized bench for mips_mem_arbiter (MEM_LAT=2).
// Memory model has one read register, matching a 2-cycle latency.
module tb_mips_mem_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic clock;
  logic reset_n;

  mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mips_mem_arbiter #(
    .MEM_LAT       (LAT),
    .MAX_DM_STREAK (SMAX)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [31:0] tmem [0:255];
  logic [31:0] rd_q;
  logic        pl_en;
  logic [7:0]  pl_a;
  logic [31:0] pl_d;

  always @(posedge clock) begin
    if (pl_en) begin
      tmem[pl_a] <= pl_d;
    end else if (bus.mem_en) begin
      if (bus.mem_we) tmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      rd_q <= tmem[bus.mem_addr[7:0]];
    end
  end
  assign bus.mem_rdata = rd_q;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] ref_mem [0:15];
  int          s;
  int          nv;
  int          ne;
  int          busy;
  bit          own_dm;
  bit          pick_dm;
  bit          exp_en, exp_iv, exp_dv;
  logic [31:0] g_addr, g_wd;
  bit          g_we;
  logic [31:0] exp_dmr;
  int          if_a, dm_a;

  initial begin
    reset_n = 1'b0;
    pl_en = 1'b0; pl_a = '0; pl_d = '0;
    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0;
    #2;
    // preload while the arbiter is held in reset
    for (int i = 0; i < 17; i++) begin
      pl_en = 1'b1;
      pl_a  = (i == 16) ? 8'h10 : 8'(i);
      pl_d  = (i == 16) ? 32'h8C010004 : $urandom;
      if (i < 16) ref_mem[i] = pl_d;
      step();
    end
    pl_en = 1'b0;
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_dm_rdata", bus.dm_rdata, 0);
    reset_n = 1'b1;
    step();

    // lone fetch
    bus.if_req = 1; bus.if_addr = 32'h10;
    step();
    chk("f_en", bus.mem_en, 1);
    chk("f_we", bus.mem_we, 0);
    chk("f_addr", bus.mem_addr, 32'h10);
    chk("f_stall", bus.stall_if, 1);
    step();
    chk("f_en_drop", bus.mem_en, 0);
    chk("f_early", bus.if_valid, 0);
    step();
    chk("f_valid", bus.if_valid, 1);
    chk("f_data", bus.if_rdata, 32'h8C010004);
    chk("f_stall_off", bus.stall_if, 0);
    bus.if_req = 0;
    step();
    chk("f_pulse", bus.if_valid, 0);
    chk("f_no_regrant", bus.mem_en, 0);

    // store then load back
    bus.dm_req = 1; bus.dm_we = 1;
    bus.dm_addr = 32'h20; bus.dm_wdata = 32'hDEADBEEF;
    step();
    chk("st_en", bus.mem_en, 1);
    chk("st_we", bus.mem_we, 1);
    chk("st_addr", bus.mem_addr, 32'h20);
    chk("st_wdata", bus.mem_wdata, 32'hDEADBEEF);
    step();
    step();
    chk("st_valid", bus.dm_valid, 1);
    chk("st_rdata_keep", bus.dm_rdata, 0);
    bus.dm_req = 0;
    step();
    bus.dm_req = 1; bus.dm_we = 0;
    step();
    step();
    step();
    chk("ld_valid", bus.dm_valid, 1);
    chk("ld_data", bus.dm_rdata, 32'hDEADBEEF);
    bus.dm_req = 0;
    step();

    // reset in the middle of a load
    bus.dm_req = 1;
    step();
    chk("mid_en", bus.mem_en, 1);
    step();
    bus.dm_req = 0;
    reset_n = 1'b0;
    #1;
    chk("mid_dm_rdata", bus.dm_rdata, 0);
    chk("mid_if_rdata", bus.if_rdata, 0);
    chk("mid_addr", bus.mem_addr, 0);
    #2;
    reset_n = 1'b1;
    nv = 0; ne = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      nv += int'(bus.dm_valid);
      ne += int'(bus.mem_en);
    end
    chk("mid_no_valid", nv, 0);
    chk("mid_no_grant", ne, 0);

    // both held: data wins until fetch has waited SMAX grants
    s = 0;
    bus.if_addr = 32'h10;
    bus.dm_addr = 32'h20; bus.dm_we = 0;
    bus.if_req = 1; bus.dm_req = 1;
    for (int g = 0; g < 11; g++) begin
      int w;
      w = 0;
      do begin
        step();
        w++;
      end while (!bus.mem_en && w < 6);
      chk("grant_seen", bus.mem_en, 1);
      pick_dm = (s != SMAX);
      s = pick_dm ? s + 1 : 0;
      chk("grant_order", bus.mem_addr,
          pick_dm ? 32'h20 : 32'h10);
    end
    bus.if_req = 0; bus.dm_req = 0;
    for (int i = 0; i < 4; i++) step();

    // dm_req dropped after issue still completes once
    bus.dm_req = 1;
    step();
    chk("drop_en", bus.mem_en, 1);
    step();
    bus.dm_req = 0;
    nv = 0; ne = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      nv += int'(bus.dm_valid);
      ne += int'(bus.mem_en);
    end
    chk("drop_valid_once", nv, 1);
    chk("drop_no_regrant", ne, 0);

    // randomized traffic against a timeline model
    s = 0; busy = 0; own_dm = 0;
    g_addr = '0; g_wd = '0; g_we = 0;
    exp_dmr = 32'hDEADBEEF;
    if_a = 0; dm_a = 0;
    for (int c = 0; c < 400; c++) begin
      exp_en = 0; exp_iv = 0; exp_dv = 0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          exp_iv = !own_dm;
          exp_dv = own_dm;
        end
      end else if (bus.if_req || bus.dm_req) begin
        pick_dm = bus.dm_req && !(bus.if_req && s == SMAX);
        if (pick_dm) s = bus.if_req ? ((s < SMAX) ? s + 1 : s) : 0;
        else s = 0;
        own_dm = pick_dm;
        busy   = LAT;
        exp_en = 1;
        g_addr = pick_dm ? 32'(dm_a) : 32'(if_a);
        g_we   = pick_dm && bus.dm_we;
        g_wd   = bus.dm_wdata;
      end
      step();
      chk("r_en", bus.mem_en, 32'(exp_en));
      if (exp_en) begin
        chk("r_addr", bus.mem_addr, g_addr);
        chk("r_we", bus.mem_we, 32'(g_we));
        if (g_we) chk("r_wdata", bus.mem_wdata, g_wd);
      end
      chk("r_if_valid", bus.if_valid, 32'(exp_iv));
      chk("r_dm_valid", bus.dm_valid, 32'(exp_dv));
      chk("r_stall_if", bus.stall_if, 32'(bus.if_req & ~exp_iv));
      chk("r_stall_dm", bus.stall_dm, 32'(bus.dm_req & ~exp_dv));
      if (exp_iv) begin
        chk("r_if_data", bus.if_rdata, ref_mem[if_a]);
        bus.if_req = 0;
      end else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        if_a = $urandom_range(0, 15);
        bus.if_addr = 32'(if_a);
        bus.if_req = 1;
      end
      if (exp_dv) begin
        if (bus.dm_we) ref_mem[dm_a] = bus.dm_wdata;
        else exp_dmr = ref_mem[dm_a];
        chk("r_dm_data", bus.dm_rdata, exp_dmr);
        bus.dm_req = 0;
      end else if (!bus.dm_req && $urandom_range(0, 1) == 0) begin
        dm_a = $urandom_range(0, 15);
        bus.dm_addr  = 32'(dm_a);
        bus.dm_we    = $urandom_range(0, 1) == 1;
        bus.dm_wdata = $urandom;
        bus.dm_req   = 1;
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
